// File: rtl/output_drain_pkg.sv
// rtl/output_drain_pkg.sv - shared widths and state encoding for the output drain
package output_drain_pkg;
   localparam int OUT_DATA_W = 16;
   localparam int ADDR_W     = 8;
   localparam int ROWS_W     = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } drain_state_e;
endpackage

// File: rtl/drain_fifo2.sv
// rtl/drain_fifo2.sv - two-entry row buffer with registered storage
module drain_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;
   logic         do_push;
   logic         do_pop;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign do_pop  = pop_i && !empty_o;
   // A push into a full buffer is legal when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= !wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= !rd_ptr_q;
         end
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/output_drain.sv
// rtl/output_drain.sv - streams a range of output-memory rows to a ready/valid consumer
module output_drain
   import output_drain_pkg::*;
#(
   parameter int WIDTH_HEIGHT = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [ADDR_W-1:0]                   base_addr,
   input  logic [ROWS_W-1:0]                   num_rows,
   output logic [WIDTH_HEIGHT-1:0]             outputMem_rd_en,
   output logic [WIDTH_HEIGHT*ADDR_W-1:0]      outputMem_rd_addr,
   input  logic [WIDTH_HEIGHT*OUT_DATA_W-1:0]  outputMem_rd_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [WIDTH_HEIGHT*OUT_DATA_W-1:0]  out_data,
   output logic                                out_last,
   output logic                                busy,
   output logic                                done
);
   localparam int ROW_W = WIDTH_HEIGHT * OUT_DATA_W;

   drain_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ROWS_W-1:0] remain_q, remain_d;
   logic              inflight_q, inflight_last_q;
   logic              done_q, done_d;

   logic              issue;
   logic              issue_last;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] addr_out;
   logic              fifo_full, fifo_empty;
   logic [ROW_W:0]    fifo_dout;
   logic              xfer;
   logic [2:0]        credit_used;
   logic              credit_ok;

   assign xfer        = out_valid && out_ready;
   // Buffer slots claimed by stored rows plus the returning read, minus the row leaving now.
   assign credit_used = {1'b0, fifo_full, !fifo_full && !fifo_empty}
                      + {2'b0, inflight_q} - {2'b0, xfer};
   assign credit_ok   = credit_used < 3'd2;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      done_d     = 1'b0;
      issue      = 1'b0;
      issue_last = 1'b0;
      issue_addr = addr_q;
      case (state_q)
         IDLE: begin
            // The buffer is always empty here, so the first read goes out with start.
            issue_addr = base_addr;
            if (start) begin
               if (num_rows == '0) begin
                  done_d = 1'b1;
               end else begin
                  issue      = 1'b1;
                  issue_last = (num_rows == ROWS_W'(1));
                  addr_d     = base_addr + ADDR_W'(1);
                  remain_d   = num_rows - ROWS_W'(1);
                  state_d    = (num_rows == ROWS_W'(1)) ? FLUSH : READ;
               end
            end
         end
         READ: begin
            if (credit_ok) begin
               issue      = 1'b1;
               issue_last = (remain_q == ROWS_W'(1));
               addr_d     = addr_q + ADDR_W'(1);
               remain_d   = remain_q - ROWS_W'(1);
               if (remain_q == ROWS_W'(1)) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (xfer && out_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remain_q        <= remain_d;
         inflight_q      <= issue;
         inflight_last_q <= issue_last;
         done_q          <= done_d;
      end
   end

   drain_fifo2 #(.W(ROW_W + 1)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (inflight_q),
      .pop_i   (out_ready),
      .data_i  ({inflight_last_q, outputMem_rd_data}),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Read strobes are combinational, so reset masks them directly.
   assign addr_out          = reset ? '0 : issue_addr;
   assign outputMem_rd_en   = {WIDTH_HEIGHT{issue && !reset}};
   assign outputMem_rd_addr = {WIDTH_HEIGHT{addr_out}};
   assign out_valid         = !fifo_empty;
   assign out_data          = fifo_dout[ROW_W-1:0];
   assign out_last          = fifo_dout[ROW_W] && !fifo_empty;
   assign busy              = (state_q != IDLE);
   assign done              = done_q;
endmodule

// File: tb/tb_output_drain.sv
// tb/tb_output_drain.sv - randomized self-checking bench for output_drain
module tb_output_drain;
   localparam int WH = 16;
   localparam int RW = WH * 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [7:0]      base_addr;
   logic [8:0]      num_rows;
   logic [WH-1:0]   rd_en;
   logic [WH*8-1:0] rd_addr;
   logic [RW-1:0]   rd_data;
   logic            out_valid;
   logic            out_ready;
   logic [RW-1:0]   out_data;
   logic            out_last;
   logic            busy;
   logic            done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int salt = 0;

   output_drain #(.WIDTH_HEIGHT(WH)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .base_addr         (base_addr),
      .num_rows          (num_rows),
      .outputMem_rd_en   (rd_en),
      .outputMem_rd_addr (rd_addr),
      .outputMem_rd_data (rd_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_last          (out_last),
      .busy              (busy),
      .done              (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] word(input logic [7:0] a, input int b);
      int v;
      v = (int'(a) * 401) ^ (b * 3869) ^ salt;
      return v[15:0];
   endfunction

   function automatic logic [RW-1:0] row(input logic [7:0] a);
      logic [RW-1:0] r;
      for (int b = 0; b < WH; b++) r[b*16 +: 16] = word(a, b);
      return r;
   endfunction

   // Memory: one-cycle latency per bank, garbage when not read.
   always @(posedge clk) begin
      for (int b = 0; b < WH; b++)
         rd_data[b*16 +: 16] <= rd_en[b] ? word(rd_addr[b*8 +: 8], b) : 16'($urandom);
   end

   bit            mon_en = 1'b0;
   bit            timed = 1'b0;
   logic [7:0]    m_base;
   logic [7:0]    exp_a;
   int            m_n, issued, xfers, done_cnt, busy_cyc, start_cyc, last_xfer_cyc, done_cyc;
   logic          stalled;
   logic [RW-1:0] held_data;
   logic          held_last;

   always @(negedge clk) begin
      if (mon_en) begin
         if (busy) busy_cyc++;
         if (stalled) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held_data);
            check("stall_last", out_last, held_last);
         end
         if (rd_en !== '0) begin
            exp_a = 8'(int'(m_base) + issued);
            check("rden_all", rd_en, {WH{1'b1}});
            check("over_issue", issued < m_n, 1);
            check("rd_addr", rd_addr, {WH{exp_a}});
            if (timed) check("issue_cyc", cyc, start_cyc + issued);
            issued++;
         end
         if (out_valid && out_ready) begin
            check("row_data", out_data, row(8'(int'(m_base) + xfers)));
            check("row_last", out_last, xfers == m_n - 1);
            if (timed) check("xfer_cyc", cyc, start_cyc + 2 + xfers);
            xfers++;
            last_xfer_cyc = cyc;
         end
         check("outstanding", (issued - xfers) <= 2, 1);
         if (done) begin
            check("done_busy", busy, 0);
            done_cnt++;
            done_cyc = cyc;
         end
         stalled   = out_valid && !out_ready;
         held_data = out_data;
         held_last = out_last;
      end
   end

   task automatic check_quiet(input string p);
      check({p, "_rden"}, rd_en, 0);
      check({p, "_rdaddr"}, rd_addr, 0);
      check({p, "_valid"}, out_valid, 0);
      check({p, "_last"}, out_last, 0);
      check({p, "_data"}, out_data, 0);
      check({p, "_busy"}, busy, 0);
      check({p, "_done"}, done, 0);
   endtask

   task automatic run_drain(input logic [7:0] b, input int n, input bit is_timed,
                            input int ready_pct, input bit dbl_start);
      int limit;
      salt          = int'($urandom);
      m_base        = b;
      m_n           = n;
      issued        = 0;
      xfers         = 0;
      done_cnt      = 0;
      busy_cyc      = 0;
      done_cyc      = -1;
      last_xfer_cyc = -1;
      stalled       = 1'b0;
      timed         = is_timed;
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = b;
      num_rows  = 9'(n);
      out_ready = is_timed ? 1'b1 : ($urandom_range(99) < ready_pct);
      start_cyc = cyc;
      mon_en    = 1'b1;
      limit     = 0;
      while (done_cnt == 0 && limit < 2000) begin
         @(posedge clk); #1;
         limit++;
         start = dbl_start && (limit == 2);
         if (start) begin
            base_addr = 8'h80;
            num_rows  = 9'd3;
         end
         out_ready = is_timed ? 1'b1 : ($urandom_range(99) < ready_pct);
      end
      check("timeout", limit < 2000, 1);
      repeat (3) begin @(posedge clk); #1; end
      mon_en = 1'b0;
      start  = 1'b0;
      check("xfer_count", xfers, n);
      check("issue_count", issued, n);
      check("done_count", done_cnt, 1);
      if (n == 0) begin
         check("zero_busy", busy_cyc, 0);
         check("zero_done_cyc", done_cyc, start_cyc + 1);
      end else begin
         check("done_cyc", done_cyc, last_xfer_cyc + 1);
      end
   endtask

   initial begin
      bit saw_done, saw_valid, saw_busy;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      num_rows  = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      reset = 1'b0;

      run_drain(8'h10, 4, 1'b1, 100, 1'b0);
      run_drain(8'hFE, 4, 1'b1, 100, 1'b0);
      run_drain(8'h00, 8, 1'b0, 50, 1'b0);
      for (int i = 0; i < 5; i++)
         run_drain(8'($urandom), int'($urandom_range(12, 1)), 1'b0, int'($urandom_range(90, 20)), 1'b0);
      run_drain(8'h55, 0, 1'b1, 100, 1'b0);
      run_drain(8'h77, 1, 1'b1, 100, 1'b0);
      run_drain(8'h20, 6, 1'b1, 100, 1'b1);
      run_drain(8'hC0, 256, 1'b1, 100, 1'b0);

      // Reset in the third cycle of a six-row drain.
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = 8'h40;
      num_rows  = 9'd6;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check_quiet("midrst");
      @(posedge clk); #1;
      reset     = 1'b0;
      saw_done  = 1'b0;
      saw_valid = 1'b0;
      saw_busy  = 1'b0;
      repeat (6) begin
         @(negedge clk);
         saw_done  |= done;
         saw_valid |= out_valid;
         saw_busy  |= busy;
      end
      check("rst_no_done", saw_done, 0);
      check("rst_discard", saw_valid, 0);
      check("rst_idle", saw_busy, 0);
      run_drain(8'h30, 6, 1'b1, 100, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
